// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS control sequencer: steps each instruction through fetch/decode/execute/memory/writeback,
// waits on the memory handshake with a bounded timeout, flags illegal opcodes and counts retired instructions.
module multicycle_control_fsm #(
    parameter int OPW     = 6,
    parameter int ALUOPW  = 7,
    parameter int TIMEOUT = 16,
    parameter int CNTW    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [OPW-1:0]    opcode,
    input  logic              zero,
    input  logic              mem_ready,
    output logic              iord,
    output logic              mem_read,
    output logic              mem_write,
    output logic              ir_write,
    output logic              pc_write,
    output logic              reg_write,
    output logic [1:0]        reg_dst,
    output logic [1:0]        mem_to_reg,
    output logic              alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic [1:0]        pc_src,
    output logic [ALUOPW-1:0] alu_op,
    output logic [3:0]        state,
    output logic              illegal,
    output logic              mem_timeout,
    output logic [CNTW-1:0]   retired
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REXEC  = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_IEXEC  = 4'd9,
        S_IWB    = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam int                WW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WW-1:0]     WAIT_LAST = WW'(TIMEOUT - 1);
    localparam logic [ALUOPW-1:0] ALU_ADD   = ALUOPW'({1'b1, OPW'(8)});

    state_t          r_state;
    logic [WW-1:0]   r_wait;
    logic [CNTW-1:0] r_retired;

    state_t w_next;
    logic   w_retire;
    logic   w_waiting;
    logic   w_timeout;
    logic   w_is_rtype;
    logic   w_is_load;
    logic   w_is_store;
    logic   w_is_branch;
    logic   w_is_imm;
    logic   w_is_jump;
    logic   w_is_legal;
    logic   w_br_taken;
    logic   w_is_jal;
    logic [ALUOPW-1:0] w_iop;

    // Opcode classes, decoded combinationally from the IR field every cycle.
    assign w_is_rtype  = (opcode == OPW'(0));
    assign w_is_load   = (opcode == OPW'(32)) || (opcode == OPW'(33)) || (opcode == OPW'(35));
    assign w_is_store  = (opcode == OPW'(40)) || (opcode == OPW'(41)) || (opcode == OPW'(43));
    assign w_is_branch = (opcode == OPW'(1))  || (opcode == OPW'(4))  || (opcode == OPW'(5));
    assign w_is_imm    = (opcode == OPW'(8))  || (opcode == OPW'(10)) ||
                         (opcode == OPW'(12)) || (opcode == OPW'(13));
    assign w_is_jump   = (opcode == OPW'(2))  || (opcode == OPW'(3));
    assign w_is_legal  = w_is_rtype | w_is_load | w_is_store | w_is_branch | w_is_imm | w_is_jump;
    assign w_is_jal    = (opcode == OPW'(3));
    assign w_br_taken  = (((opcode == OPW'(1)) || (opcode == OPW'(4))) && zero) ||
                         ((opcode == OPW'(5)) && !zero);
    assign w_iop       = ALUOPW'({1'b1, opcode});

    assign w_waiting = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
    assign w_timeout = w_waiting && !mem_ready && (r_wait == WAIT_LAST);

    always_comb begin
        // NOTE: give every combinational output a default before the case so no path leaves it unassigned (latch).
        w_next   = r_state;
        w_retire = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (mem_ready)      w_next = S_DECODE;
                else if (w_timeout) w_next = S_FETCH;
            end
            S_DECODE: begin
                if (w_is_rtype)                   w_next = S_REXEC;
                else if (w_is_load || w_is_store) w_next = S_MEMADR;
                else if (w_is_branch)             w_next = S_BRANCH;
                else if (w_is_imm)                w_next = S_IEXEC;
                else if (w_is_jump)               w_next = S_JUMP;
                else                              w_next = S_FETCH;
            end
            S_MEMADR: begin
                if (w_is_load)       w_next = S_MEMRD;
                else if (w_is_store) w_next = S_MEMWR;
                else                 w_next = S_FETCH;
            end
            S_MEMRD: begin
                if (mem_ready)      w_next = S_MEMWB;
                else if (w_timeout) w_next = S_FETCH;
            end
            S_MEMWR: begin
                if (mem_ready) begin
                    w_next   = S_FETCH;
                    w_retire = 1'b1;
                end else if (w_timeout) begin
                    w_next = S_FETCH;
                end
            end
            S_REXEC: w_next = S_ALUWB;
            S_IEXEC: w_next = S_IWB;
            S_MEMWB, S_ALUWB, S_IWB, S_BRANCH, S_JUMP: begin
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_wait    <= '0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            // A timeout re-enters FETCH from FETCH, so it must clear the count explicitly.
            if (w_timeout || (w_next != r_state))
                r_wait <= '0;
            else if (w_waiting && !mem_ready)
                r_wait <= r_wait + WW'(1);
            if (w_retire)
                r_retired <= r_retired + CNTW'(1);
        end
    end

    // Control decode from current state; everything is forced low while rst is high.
    // Write strobes in wait states only fire with mem_ready=1, which already excludes a timeout cycle.
    always_comb begin
        iord        = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = 2'd0;
        mem_to_reg  = 2'd0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'd0;
        pc_src      = 2'd0;
        alu_op      = '0;
        illegal     = 1'b0;
        mem_timeout = 1'b0;
        if (!rst) begin
            mem_timeout = w_timeout;
            case (r_state)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'd1;
                    alu_op    = ALU_ADD;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b = 2'd3;
                    alu_op    = ALU_ADD;
                    illegal   = !w_is_legal;
                end
                S_MEMADR, S_IEXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'd2;
                    alu_op    = w_iop;
                end
                S_MEMRD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 2'd1;
                end
                S_MEMWR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                end
                S_REXEC: alu_src_a = 1'b1;
                S_ALUWB: begin
                    reg_write = 1'b1;
                    reg_dst   = 2'd1;
                end
                S_IWB: reg_write = 1'b1;
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op    = w_iop;
                    pc_src    = 2'd1;
                    pc_write  = w_br_taken;
                end
                S_JUMP: begin
                    pc_write = 1'b1;
                    pc_src   = 2'd2;
                    // jal links through the PC, which already holds PC+4.
                    if (w_is_jal) begin
                        reg_write  = 1'b1;
                        reg_dst    = 2'd2;
                        mem_to_reg = 2'd2;
                    end
                end
                default: ;
            endcase
        end
    end

    assign state   = r_state;
    assign retired = r_retired;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: an instruction-path model checked every cycle plus directed literal checks.
module tb_multicycle_control_fsm;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  opcode = 6'd0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        iord, mem_read, mem_write, ir_write, pc_write, reg_write;
    logic [1:0]  reg_dst, mem_to_reg, alu_src_b, pc_src;
    logic        alu_src_a, illegal, mem_timeout;
    logic [6:0]  alu_op;
    logic [3:0]  state;
    logic [31:0] retired;

    multicycle_control_fsm #(.OPW(6), .ALUOPW(7), .TIMEOUT(TIMEOUT), .CNTW(32)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .pc_write(pc_write), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_op(alu_op),
        .state(state), .illegal(illegal), .mem_timeout(mem_timeout), .retired(retired)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic       iord, mem_read, mem_write, ir_write, pc_write, reg_write;
        logic [1:0] reg_dst, mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b, pc_src;
        logic [6:0] alu_op;
        logic       illegal, mem_timeout;
    } ctl_t;

    // Expected controls from the meaning of each step of an instruction.
    function automatic ctl_t expect_ctl(int st, logic [5:0] op, logic z, logic rdy, logic r, logic tmo);
        ctl_t c;
        logic [6:0] iop;
        c   = '0;
        iop = {1'b1, op};
        if (r) return c;
        case (st)
            0: begin c.mem_read = 1; c.alu_src_b = 1; c.alu_op = 7'h48; c.ir_write = rdy; c.pc_write = rdy; end
            1: begin
                c.alu_src_b = 3; c.alu_op = 7'h48;
                c.illegal = !(op inside {6'd0, 6'd32, 6'd33, 6'd35, 6'd40, 6'd41, 6'd43,
                                         6'd1, 6'd4, 6'd5, 6'd8, 6'd10, 6'd12, 6'd13, 6'd2, 6'd3});
            end
            2, 9: begin c.alu_src_a = 1; c.alu_src_b = 2; c.alu_op = iop; end
            3: begin c.mem_read = 1; c.iord = 1; end
            4: begin c.reg_write = 1; c.mem_to_reg = 1; end
            5: begin c.mem_write = 1; c.iord = 1; end
            6: c.alu_src_a = 1;
            7: begin c.reg_write = 1; c.reg_dst = 1; end
            10: c.reg_write = 1;
            8: begin
                c.alu_src_a = 1; c.alu_op = iop; c.pc_src = 1;
                c.pc_write = (op == 6'd5) ? !z : z;
            end
            11: begin
                c.pc_write = 1; c.pc_src = 2;
                if (op == 6'd3) begin c.reg_write = 1; c.reg_dst = 2; c.mem_to_reg = 2; end
            end
            default: ;
        endcase
        c.mem_timeout = tmo;
        return c;
    endfunction

    // Model: current step, the post-decode path of the instruction, wait count and retire count.
    int          m_st = 0;
    int          m_wait = 0;
    int          m_path[3];
    int          m_len = 0;
    int          m_idx = 0;
    logic [31:0] m_ret = 0;

    task automatic advance();
        m_idx++;
        if (m_idx >= m_len) begin
            m_st = 0;
            m_ret++;
        end else begin
            m_st = m_path[m_idx];
        end
    endtask

    always @(negedge clk) begin
        ctl_t exp_c, act_c;
        logic tmo;
        tmo   = !rst && (m_st inside {0, 3, 5}) && !mem_ready && (m_wait == TIMEOUT - 1);
        exp_c = expect_ctl(m_st, opcode, zero, mem_ready, rst, tmo);
        act_c = {iord, mem_read, mem_write, ir_write, pc_write, reg_write, reg_dst, mem_to_reg,
                 alu_src_a, alu_src_b, pc_src, alu_op, illegal, mem_timeout};
        check($sformatf("ctl@st%0d", m_st), 64'(act_c), 64'(exp_c));
        check("state", 64'(state), 64'(m_st));
        check("retired", 64'(retired), 64'(m_ret));
        if (rst) begin
            m_st = 0; m_wait = 0; m_ret = 0;
        end else if (m_st inside {0, 3, 5}) begin
            if (mem_ready) begin
                m_wait = 0;
                if (m_st == 0) m_st = 1;
                else advance();
            end else if (tmo) begin
                m_wait = 0; m_st = 0;
            end else begin
                m_wait++;
            end
        end else if (m_st == 1) begin
            m_idx = 0;
            if (opcode == 6'd0)                              begin m_path = '{6, 7, 0};  m_len = 2; end
            else if (opcode inside {6'd32, 6'd33, 6'd35})    begin m_path = '{2, 3, 4};  m_len = 3; end
            else if (opcode inside {6'd40, 6'd41, 6'd43})    begin m_path = '{2, 5, 0};  m_len = 2; end
            else if (opcode inside {6'd1, 6'd4, 6'd5})       begin m_path = '{8, 0, 0};  m_len = 1; end
            else if (opcode inside {6'd8, 6'd10, 6'd12, 6'd13}) begin m_path = '{9, 10, 0}; m_len = 2; end
            else if (opcode inside {6'd2, 6'd3})             begin m_path = '{11, 0, 0}; m_len = 1; end
            else m_len = 0;
            m_st = (m_len == 0) ? 0 : m_path[0];
        end else begin
            advance();
        end
    end

    // One cycle: inputs change just after the rising edge, caller inspects outputs at the falling edge.
    task automatic drive(input logic r, input logic [5:0] op, input logic rdy, input logic z);
        @(posedge clk);
        #1;
        rst = r; opcode = op; mem_ready = rdy; zero = z;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] seq;
        logic [2:0]  rw;
        int          n3, pulses, ir_any;

        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        check("reset_state", 64'(state), 64'd0);
        check("reset_retired", 64'(retired), 64'd0);
        check("reset_strobes", 64'({mem_read, ir_write, pc_write, reg_write}), 64'd0);

        // R-type: FETCH, DECODE, REXEC, ALUWB
        seq = '0; rw = '0;
        for (int i = 0; i < 4; i++) begin
            drive(0, 6'd0, 1, 0);
            seq = {seq[11:0], state};
            if (i == 3) rw = {reg_write, reg_dst};
        end
        check("rtype_states", 64'(seq), 64'h0167);
        check("rtype_aluwb_write", 64'(rw), 64'b101);

        // lw with three not-ready cycles in MEMRD
        drive(0, 6'd35, 1, 0);
        check("rtype_retired", 64'(retired), 64'd1);
        drive(0, 6'd35, 1, 0);
        drive(0, 6'd35, 1, 0);
        n3 = 0;
        for (int i = 0; i < 4; i++) begin
            drive(0, 6'd35, (i == 3), 0);
            if (state == 4'd3) n3++;
        end
        drive(0, 6'd35, 1, 0);
        if (state == 4'd3) n3++;
        check("lw_memrd_cycles", 64'(n3), 64'd4);
        check("lw_memwb", 64'({reg_write, mem_to_reg}), 64'b101);

        // beq taken, beq not taken, bne taken
        drive(0, 6'd4, 1, 1);
        check("lw_retired", 64'(retired), 64'd2);
        drive(0, 6'd4, 1, 1);
        drive(0, 6'd4, 1, 1);
        check("beq_taken", 64'({state, pc_write, pc_src}), 64'({4'd8, 1'b1, 2'd1}));
        drive(0, 6'd4, 1, 0);
        drive(0, 6'd4, 1, 0);
        drive(0, 6'd4, 1, 0);
        check("beq_not_taken", 64'({pc_write, pc_src}), 64'b001);
        drive(0, 6'd5, 1, 0);
        drive(0, 6'd5, 1, 0);
        drive(0, 6'd5, 1, 0);
        check("bne_taken", 64'({pc_write, pc_src}), 64'b101);

        // jal then j
        drive(0, 6'd3, 1, 0);
        drive(0, 6'd3, 1, 0);
        drive(0, 6'd3, 1, 0);
        check("jal_jump", 64'({pc_write, pc_src, reg_write, reg_dst, mem_to_reg}), 64'b1_10_1_10_10);
        drive(0, 6'd2, 1, 0);
        drive(0, 6'd2, 1, 0);
        drive(0, 6'd2, 1, 0);
        check("j_jump", 64'({pc_write, pc_src, reg_write, reg_dst, mem_to_reg}), 64'b1_10_0_00_00);

        // FETCH starved: timeout on the 16th cycle
        pulses = 0; ir_any = 0;
        for (int i = 1; i <= 16; i++) begin
            drive(0, 6'd0, 0, 0);
            if (i == 1) check("j_retired", 64'(retired), 64'd7);
            if (i == 16) check("fetch_timeout_pulse", 64'(mem_timeout), 64'd1);
            pulses += int'(mem_timeout);
            ir_any += int'(ir_write);
        end
        check("fetch_timeout_count", 64'(pulses), 64'd1);
        check("fetch_timeout_no_irwrite", 64'(ir_any), 64'd0);
        drive(0, 6'd0, 0, 0);
        check("after_timeout", 64'({state, mem_timeout}), 64'd0);
        check("after_timeout_retired", 64'(retired), 64'd7);

        // sw, then addi
        for (int i = 0; i < 4; i++) drive(0, 6'd43, 1, 0);
        drive(0, 6'd8, 1, 0);
        check("sw_retired", 64'(retired), 64'd8);
        drive(0, 6'd8, 1, 0);
        drive(0, 6'd8, 1, 0);
        check("addi_iexec", 64'({alu_op, alu_src_b}), 64'({7'h48, 2'd2}));
        drive(0, 6'd8, 1, 0);
        check("addi_iwb", 64'({reg_write, reg_dst, mem_to_reg}), 64'b1_00_00);

        // lw whose memory answers exactly on the last allowed cycle
        drive(0, 6'd35, 1, 0);
        check("addi_retired", 64'(retired), 64'd9);
        drive(0, 6'd35, 1, 0);
        drive(0, 6'd35, 1, 0);
        check("lw_memadr_aluop", 64'(alu_op), 64'h63);
        for (int i = 0; i < 15; i++) drive(0, 6'd35, 0, 0);
        drive(0, 6'd35, 1, 0);
        check("memrd_last_cycle", 64'({state, mem_timeout}), 64'({4'd3, 1'b0}));
        drive(0, 6'd35, 1, 0);
        check("memrd_last_cycle_wb", 64'(state), 64'd4);

        // illegal opcode
        drive(0, 6'd63, 1, 0);
        check("lw2_retired", 64'(retired), 64'd10);
        drive(0, 6'd63, 1, 0);
        check("illegal_pulse", 64'(illegal), 64'd1);
        drive(0, 6'd63, 0, 0);
        check("illegal_next", 64'({state, illegal}), 64'd0);
        check("illegal_retired", 64'(retired), 64'd10);

        // reset asserted while in MEMWR
        drive(0, 6'd43, 1, 0);
        drive(0, 6'd43, 1, 0);
        drive(0, 6'd43, 1, 0);
        drive(1, 6'd43, 1, 0);
        check("rst_in_memwr", 64'({state, mem_write}), 64'({4'd5, 1'b0}));
        drive(0, 6'd43, 0, 0);
        check("rst_in_memwr_next", 64'(state), 64'd0);
        check("rst_in_memwr_retired", 64'(retired), 64'd0);
        drive(0, 6'd0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Multicycle successor to the single-cycle opcode decoder in the MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and writeback states, and drives datapath controls per state. It waits on a memory ready handshake, with a parametrised timeout. It also flags illegal opcodes and counts retired instructions. It sits between the instruction register opcode field and the shared-memory multicycle datapath.

Parameters:
OPW, 6, opcode width (instr[31:26])
ALUOPW, 7, ALU op width; ALU codes are {1'b1, opcode} for I-class and all-zero for R-type
TIMEOUT, 16, max cycles waited on mem_ready before abort (>=1)
CNTW, 32, width of retired-instruction counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
opcode  in  OPW  instr[31:26] from IR, valid from DECODE onward
zero  in  1  ALU compare flag
mem_ready  in  1  memory completes current read/write this cycle
iord  out  1  0=PC addresses memory, 1=ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  load IR
pc_write  out  1  load PC
reg_write  out  1  register file write
reg_dst  out  2  0=rt, 1=rd, 2=r31
mem_to_reg  out  2  0=ALUOut, 1=MDR, 2=PC
alu_src_a  out  1  0=PC, 1=rs
alu_src_b  out  2  0=rt, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2
pc_src  out  2  0=ALU result, 1=ALUOut (branch target), 2=jump target
alu_op  out  ALUOPW  ALU operation code
state  out  4  current state (debug)
illegal  out  1  one-cycle pulse, unsupported opcode
mem_timeout  out  1  one-cycle pulse, handshake abort
retired  out  CNTW  completed instructions

Behaviour:
- Reset: while rst=1, state<=FETCH (0), wait counter<=0, retired<=0. All control outputs, illegal and mem_timeout are 0 during the rst cycle.
- States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, REXEC=6, ALUWB=7, BRANCH=8, IEXEC=9, IWB=10, JUMP=11. Codes 12-15 are unreachable; if entered, go to FETCH.
- ADD code = {1'b1, 6'd8}.
- Any output not listed for a state is 0.
- FETCH:
  - Outputs: mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=ADD, pc_src=0.
  - ir_write and pc_write = mem_ready (Mealy).
  - On mem_ready go to DECODE; otherwise hold.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=3, alu_op=ADD (precomputes the branch target).
  - Opcode classes and next state:
    - 0 (R-type) -> REXEC
    - 32, 33, 35 (load) or 40, 41, 43 (store) -> MEMADR
    - 1, 4, 5 (branch) -> BRANCH
    - 8, 10, 12, 13 (immediate) -> IEXEC
    - 2, 3 (jump) -> JUMP
    - any other -> FETCH, with illegal=1 for this cycle and retired unchanged.
- MEMADR:
  - Outputs: alu_src_a=1, alu_src_b=2, alu_op={1,opcode}.
  - Next state: MEMRD for a load, MEMWR for a store.
- MEMRD: mem_read=1, iord=1. Hold until mem_ready, then go to MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1. Next FETCH.
- MEMWR: mem_write=1, iord=1. Hold until mem_ready, then go to FETCH.
- REXEC: alu_src_a=1, alu_src_b=0, alu_op=0. Next ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0. Next FETCH.
- IEXEC: alu_src_a=1, alu_src_b=2, alu_op={1,opcode}. Next IWB.
- IWB: reg_write=1, reg_dst=0, mem_to_reg=0. Next FETCH.
- BRANCH:
  - Outputs: alu_src_a=1, alu_src_b=0, alu_op={1,opcode}, pc_src=1.
  - pc_write = (opcode in {1,4} & zero) | (opcode==5 & ~zero).
  - Next FETCH.
- JUMP: pc_write=1, pc_src=2. If opcode==3 also reg_write=1, reg_dst=2, mem_to_reg=2 (PC already holds PC+4). Next FETCH.
- Wait counter:
  - Cleared on entry to FETCH, MEMRD and MEMWR. Increments each cycle spent in those states with mem_ready=0.
  - If the count reaches TIMEOUT-1 with mem_ready still 0: pulse mem_timeout for that cycle, go to FETCH, suppress ir_write, pc_write and reg_write.
  - mem_ready=1 on the TIMEOUT-1 cycle completes normally; no timeout.
- retired:
  - Increments by 1 on every transition into FETCH from MEMWB, MEMWR (completed), ALUWB, IWB, BRANCH or JUMP.
  - No increment on illegal or timeout. Wraps modulo 2^CNTW.
- Latency with mem_ready always 1: load 5 cycles; store, R-type and immediate 4 cycles; branch and jump 3 cycles.
- The opcode input is sampled combinationally every cycle; the IR must hold it stable from DECODE until return to FETCH.
- rst mid-instruction: abort at the next edge, state=FETCH, no write strobes during the rst cycle.

Test Plan:
- Reset, then opcode=0 with mem_ready=1 -> states 0,1,6,7,0; reg_write=1 with reg_dst=1 only in ALUWB; retired=1.
- lw (35) with mem_ready low for 3 cycles in MEMRD -> MEMRD held for 4 cycles; MEMWB has reg_write=1, mem_to_reg=1; retired increments once.
- beq (4) with zero=1 -> pc_write=1 and pc_src=1 in BRANCH. Repeat with zero=0 -> pc_write=0. bne (5) with zero=0 -> pc_write=1.
- jal (3) -> JUMP asserts pc_write=1, pc_src=2, reg_write=1, reg_dst=2, mem_to_reg=2. j (2) -> reg_write=0.
- mem_ready held 0 in FETCH, TIMEOUT=16 -> mem_timeout pulses on the 16th FETCH cycle; ir_write never asserted; retired unchanged; state returns to FETCH.
- opcode=63 -> illegal pulses in DECODE, next state FETCH, retired unchanged. rst asserted in MEMWR -> mem_write=0 that cycle, state=0 next.
